// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: run-time programmable serial pattern-detect controller.
//
// A pattern configuration (bits, length, overlap mode, match target) is taken
// over a valid/ready handshake while idle or done. A start strobe arms a run.
// During the run every qualified serial bit is shifted in. Each time the most
// recent cfg_len bits equal the pattern, a one-cycle match pulse is issued and
// a saturating counter is bumped. The run ends with a done pulse once the
// counter reaches a non-zero target.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   cfg_valid/ready    configuration handshake (ready in IDLE or DONE)
//   cfg_pattern        pattern bits, bit cfg_len-1 arrives first
//   cfg_len            pattern length, legal 1..PAT_W
//   cfg_overlap        1 = matched bits may be reused by the next match
//   cfg_target         match count that ends the run, 0 = run until abort
//   cfg_err            one-cycle pulse when an illegal cfg_len is rejected
//   start, abort       begin a run / return to IDLE
//   din_valid, din     qualified serial input stream
//   busy               high while running
//   match              one-cycle pulse per detected pattern
//   match_count        matches in this run, saturating
//   done               one-cycle pulse when match_count reaches cfg_target
module seq_det_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  output logic             cfg_err,
  input  logic             start,
  input  logic             abort,
  input  logic             din_valid,
  input  logic             din,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_reg, state_next;
  logic [PAT_W-1:0] pattern_reg, pattern_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic             overlap_reg, overlap_next;
  logic [CNT_W-1:0] target_reg, target_next;
  // The oldest bit of a full-width window is never compared after the next
  // shift, so only PAT_W-1 history bits are stored.
  logic [PAT_W-2:0] sh_reg, sh_next;
  logic [LEN_W-1:0] bits_seen_reg, bits_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             match_reg, match_next;
  logic             done_reg, done_next;
  logic             busy_reg, busy_next;
  logic             cfg_err_reg, cfg_err_next;

  logic [PAT_W-1:0] sh_new;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W:0]   bits_plus;
  logic             len_ok;
  logic             cfg_fire;
  logic             cfg_accept;
  logic             cfg_reject;
  logic             hit;
  logic [CNT_W-1:0] count_inc;
  logic             target_hit;

  assign cfg_ready = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign len_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
  // An abort taken in DONE wins over a configuration offered in the same cycle.
  assign cfg_fire   = cfg_valid && cfg_ready && !(abort && (state_reg == S_DONE));
  assign cfg_accept = cfg_fire && len_ok;
  assign cfg_reject = cfg_fire && !len_ok;

  // Window compare only looks at the low len_reg bits.
  for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
    assign len_mask[gi] = (len_reg > LEN_W'(gi));
  end

  assign sh_new     = {sh_reg, din};
  assign bits_plus  = {1'b0, bits_seen_reg} + (LEN_W+1)'(1);
  assign hit        = (bits_plus >= {1'b0, len_reg}) &&
                      (((sh_new ^ pattern_reg) & len_mask) == '0);
  assign count_inc  = (count_reg == {CNT_W{1'b1}}) ? count_reg
                                                   : count_reg + CNT_W'(1);
  assign target_hit = (target_reg != '0) && (count_inc == target_reg);

  always_comb begin
    state_next   = state_reg;
    pattern_next = pattern_reg;
    len_next     = len_reg;
    overlap_next = overlap_reg;
    target_next  = target_reg;
    sh_next      = sh_reg;
    bits_next    = bits_seen_reg;
    count_next   = count_reg;
    match_next   = 1'b0;
    done_next    = 1'b0;

    case (state_reg)
      S_ARMED: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (start) begin
          state_next = S_RUN;
          sh_next    = '0;
          bits_next  = '0;
          count_next = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (din_valid) begin
          sh_next = sh_new[PAT_W-2:0];
          if (bits_plus > (LEN_W+1)'(PAT_W)) begin
            bits_next = LEN_W'(PAT_W);
          end else begin
            bits_next = bits_plus[LEN_W-1:0];
          end
          if (hit) begin
            match_next = 1'b1;
            count_next = count_inc;
            // Non-overlap: the matched bits must not count toward the next hit.
            if (!overlap_reg) begin
              bits_next = '0;
            end
            if (target_hit) begin
              done_next  = 1'b1;
              state_next = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (start && !cfg_accept) begin
          state_next = S_RUN;
          sh_next    = '0;
          bits_next  = '0;
          count_next = '0;
        end
      end
      default: ;
    endcase

    // A legal configuration always lands in ARMED, even if start was also seen.
    if (cfg_accept) begin
      pattern_next = cfg_pattern;
      len_next     = cfg_len;
      overlap_next = cfg_overlap;
      target_next  = cfg_target;
      state_next   = S_ARMED;
    end

    cfg_err_next = cfg_reject;
    busy_next    = (state_next == S_RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      pattern_reg   <= '0;
      len_reg       <= '0;
      overlap_reg   <= 1'b0;
      target_reg    <= '0;
      sh_reg        <= '0;
      bits_seen_reg <= '0;
      count_reg     <= '0;
      match_reg     <= 1'b0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      cfg_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pattern_reg   <= pattern_next;
      len_reg       <= len_next;
      overlap_reg   <= overlap_next;
      target_reg    <= target_next;
      sh_reg        <= sh_next;
      bits_seen_reg <= bits_next;
      count_reg     <= count_next;
      match_reg     <= match_next;
      done_reg      <= done_next;
      busy_reg      <= busy_next;
      cfg_err_reg   <= cfg_err_next;
    end
  end

  assign match       = match_reg;
  assign done        = done_reg;
  assign busy        = busy_reg;
  assign match_count = count_reg;
  assign cfg_err     = cfg_err_reg;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Testbench for seq_det_ctrl. A default instance (CNT_W=8) and a narrow
// instance (CNT_W=2) share all stimulus; the narrow one exposes counter
// saturation. Expected outputs are queued as stimulus is driven and popped
// after the sampling edge.
module tb_seq_det_ctrl;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int LEN_W = $clog2(PAT_W) + 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic [CNT_W-1:0] cfg_target = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             din_valid = 1'b0;
  logic             din = 1'b0;

  logic             cfg_ready, cfg_err, busy, match, done;
  logic [CNT_W-1:0] match_count;
  logic             s_ready, s_err, s_busy, s_match, s_done;
  logic [1:0]       s_count;
  logic [1:0]       s_target;

  assign s_target = cfg_target[1:0];

  always #5 clk = ~clk;

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .cfg_err(cfg_err),
    .start(start), .abort(abort), .din_valid(din_valid), .din(din),
    .busy(busy), .match(match), .match_count(match_count), .done(done)
  );

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(2)) u_sat (
    .clk(clk), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(s_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_target(s_target), .cfg_err(s_err),
    .start(start), .abort(abort), .din_valid(din_valid), .din(din),
    .busy(s_busy), .match(s_match), .match_count(s_count), .done(s_done)
  );

  typedef struct {
    logic       m;
    logic       dn;
    logic [7:0] cnt;
    logic       bsy;
    logic       rdy;
    logic       err;
  } exp_t;

  typedef struct {
    logic dv;
    logic d;
    logic st;
    logic ab;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  vec_t t1[12];
  vec_t t3[8];
  vec_t t2[8];
  vec_t t4[8];
  vec_t t5[5];
  vec_t t6[6];
  vec_t t7[8];

  function automatic exp_t mk(logic m, logic dn, logic [7:0] cnt,
                              logic bsy, logic rdy, logic err);
    exp_t e;
    e.m = m; e.dn = dn; e.cnt = cnt; e.bsy = bsy; e.rdy = rdy; e.err = err;
    return e;
  endfunction

  function automatic vec_t mkv(logic dv, logic d, logic st, logic ab, exp_t e);
    vec_t v;
    v.dv = dv; v.d = d; v.st = st; v.ab = ab; v.e = e;
    return v;
  endfunction

  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s %s: got %0d, expected %0d", name, field, act, req);
    end
  endtask

  task automatic check_pop(input string name);
    exp_t e;
    logic [1:0] sat_cnt;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s scoreboard: got empty queue, expected an entry", name);
    end else begin
      e = sb.pop_front();
      sat_cnt = (e.cnt > 8'd3) ? 2'd3 : e.cnt[1:0];
      $display("txn %-14s match=%b done=%b count=%0d busy=%b ready=%b err=%b | sat match=%b count=%0d",
               name, match, done, match_count, busy, cfg_ready, cfg_err, s_match, s_count);
      cmp(name, "match",       32'(match),       32'(e.m));
      cmp(name, "done",        32'(done),        32'(e.dn));
      cmp(name, "match_count", 32'(match_count), 32'(e.cnt));
      cmp(name, "busy",        32'(busy),        32'(e.bsy));
      cmp(name, "cfg_ready",   32'(cfg_ready),   32'(e.rdy));
      cmp(name, "cfg_err",     32'(cfg_err),     32'(e.err));
      cmp(name, "sat_match",   32'(s_match),     32'(e.m));
      cmp(name, "sat_done",    32'(s_done),      32'(e.dn));
      cmp(name, "sat_count",   32'(s_count),     32'(sat_cnt));
      cmp(name, "sat_busy",    32'(s_busy),      32'(e.bsy));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input string name, input exp_t e);
    sb.push_back(e);
    tick();
    check_pop(name);
  endtask

  task automatic apply_vec(input string name, input vec_t v);
    din_valid = v.dv;
    din       = v.d;
    start     = v.st;
    abort     = v.ab;
    apply(name, v.e);
    din_valid = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic do_cfg(input string name, input logic [7:0] pat,
                        input logic [LEN_W-1:0] len, input logic ov,
                        input logic [7:0] tgt, input exp_t e);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    cfg_target  = tgt;
    cfg_valid   = 1'b1;
    apply(name, e);
    cfg_valid   = 1'b0;
  endtask

  task automatic do_start(input string name, input exp_t e);
    start = 1'b1;
    apply(name, e);
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected end within time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Non-overlap, target 2: 1011 0 11 | 1 0 11 (reused bits must not match)
    t1[0]  = mkv(1, 1, 0, 0, mk(0, 0, 0, 1, 0, 0));
    t1[1]  = mkv(1, 0, 0, 0, mk(0, 0, 0, 1, 0, 0));
    t1[2]  = mkv(1, 1, 0, 0, mk(0, 0, 0, 1, 0, 0));
    t1[3]  = mkv(1, 1, 0, 0, mk(1, 0, 1, 1, 0, 0));
    t1[4]  = mkv(1, 0, 0, 0, mk(0, 0, 1, 1, 0, 0));
    t1[5]  = mkv(1, 1, 0, 0, mk(0, 0, 1, 1, 0, 0));
    t1[6]  = mkv(1, 1, 0, 0, mk(0, 0, 1, 1, 0, 0));
    t1[7]  = mkv(1, 1, 0, 0, mk(0, 0, 1, 1, 0, 0));
    t1[8]  = mkv(1, 0, 0, 0, mk(0, 0, 1, 1, 0, 0));
    t1[9]  = mkv(1, 1, 0, 0, mk(0, 0, 1, 1, 0, 0));
    t1[10] = mkv(1, 1, 0, 0, mk(1, 1, 2, 0, 1, 0));
    t1[11] = mkv(1, 1, 0, 0, mk(0, 0, 2, 0, 1, 0));  // din ignored in DONE
    // Rerun from DONE with the retained config: 1011 1011
    t3[0] = mkv(1, 1, 0, 0, mk(0, 0, 0, 1, 0, 0));
    t3[1] = mkv(1, 0, 0, 0, mk(0, 0, 0, 1, 0, 0));
    t3[2] = mkv(1, 1, 0, 0, mk(0, 0, 0, 1, 0, 0));
    t3[3] = mkv(1, 1, 0, 0, mk(1, 0, 1, 1, 0, 0));
    t3[4] = mkv(1, 1, 0, 0, mk(0, 0, 1, 1, 0, 0));
    t3[5] = mkv(1, 0, 0, 0, mk(0, 0, 1, 1, 0, 0));
    t3[6] = mkv(1, 1, 0, 0, mk(0, 0, 1, 1, 0, 0));
    t3[7] = mkv(1, 1, 0, 0, mk(1, 1, 2, 0, 1, 0));
    // Overlap, target 0: 1011011 matches at bits 4 and 7, then abort
    t2[0] = mkv(1, 1, 0, 0, mk(0, 0, 0, 1, 0, 0));
    t2[1] = mkv(1, 0, 0, 0, mk(0, 0, 0, 1, 0, 0));
    t2[2] = mkv(1, 1, 0, 0, mk(0, 0, 0, 1, 0, 0));
    t2[3] = mkv(1, 1, 0, 0, mk(1, 0, 1, 1, 0, 0));
    t2[4] = mkv(1, 0, 0, 0, mk(0, 0, 1, 1, 0, 0));
    t2[5] = mkv(1, 1, 0, 0, mk(0, 0, 1, 1, 0, 0));
    t2[6] = mkv(1, 1, 0, 0, mk(1, 0, 2, 1, 0, 0));
    t2[7] = mkv(0, 0, 0, 1, mk(0, 0, 2, 0, 1, 0));
    // Gapped stream: invalid cycles carry misleading din values
    t4[0] = mkv(1, 1, 0, 0, mk(0, 0, 0, 1, 0, 0));
    t4[1] = mkv(0, 0, 0, 0, mk(0, 0, 0, 1, 0, 0));
    t4[2] = mkv(1, 0, 0, 0, mk(0, 0, 0, 1, 0, 0));
    t4[3] = mkv(0, 1, 0, 0, mk(0, 0, 0, 1, 0, 0));
    t4[4] = mkv(1, 1, 0, 0, mk(0, 0, 0, 1, 0, 0));
    t4[5] = mkv(0, 0, 0, 0, mk(0, 0, 0, 1, 0, 0));
    t4[6] = mkv(1, 1, 0, 0, mk(1, 0, 1, 1, 0, 0));
    t4[7] = mkv(0, 0, 0, 0, mk(0, 0, 1, 1, 0, 0));
    // Abort on the completing bit: no pulse, count held, IDLE
    t5[0] = mkv(1, 1, 0, 0, mk(0, 0, 1, 1, 0, 0));
    t5[1] = mkv(1, 0, 0, 0, mk(0, 0, 1, 1, 0, 0));
    t5[2] = mkv(1, 1, 0, 0, mk(0, 0, 1, 1, 0, 0));
    t5[3] = mkv(1, 1, 0, 1, mk(0, 0, 1, 0, 1, 0));
    t5[4] = mkv(1, 1, 0, 0, mk(0, 0, 1, 0, 1, 0));
    // Length-1 pattern '1', overlap: five matches, narrow counter stops at 3
    t6[0] = mkv(1, 1, 0, 0, mk(1, 0, 1, 1, 0, 0));
    t6[1] = mkv(1, 1, 0, 0, mk(1, 0, 2, 1, 0, 0));
    t6[2] = mkv(1, 1, 0, 0, mk(1, 0, 3, 1, 0, 0));
    t6[3] = mkv(1, 1, 0, 0, mk(1, 0, 4, 1, 0, 0));
    t6[4] = mkv(1, 1, 0, 0, mk(1, 0, 5, 1, 0, 0));
    t6[5] = mkv(1, 0, 0, 0, mk(0, 0, 5, 1, 0, 0));
    // Full-length pattern A5, target 1
    t7[0] = mkv(1, 1, 0, 0, mk(0, 0, 0, 1, 0, 0));
    t7[1] = mkv(1, 0, 0, 0, mk(0, 0, 0, 1, 0, 0));
    t7[2] = mkv(1, 1, 0, 0, mk(0, 0, 0, 1, 0, 0));
    t7[3] = mkv(1, 0, 0, 0, mk(0, 0, 0, 1, 0, 0));
    t7[4] = mkv(1, 0, 0, 0, mk(0, 0, 0, 1, 0, 0));
    t7[5] = mkv(1, 1, 0, 0, mk(0, 0, 0, 1, 0, 0));
    t7[6] = mkv(1, 0, 0, 0, mk(0, 0, 0, 1, 0, 0));
    t7[7] = mkv(1, 1, 0, 0, mk(1, 1, 1, 0, 1, 0));

    // Reset state
    tick();
    tick();
    sb.push_back(mk(0, 0, 0, 0, 1, 0));
    check_pop("reset");
    reset_n = 1'b1;
    apply("idle", mk(0, 0, 0, 0, 1, 0));

    // Non-overlap run to DONE
    do_cfg("t1_cfg", 8'b1011, 4'd4, 1'b0, 8'd2, mk(0, 0, 0, 0, 0, 0));
    do_start("t1_start", mk(0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 12; i++) apply_vec($sformatf("t1_%0d", i), t1[i]);

    // Illegal lengths rejected in DONE, then rerun with retained config
    do_cfg("err_len0_done", 8'hFF, 4'd0, 1'b1, 8'd0, mk(0, 0, 2, 0, 1, 1));
    do_cfg("err_len9_done", 8'hFF, 4'd9, 1'b1, 8'd0, mk(0, 0, 2, 0, 1, 1));
    do_start("t3_start", mk(0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 8; i++) apply_vec($sformatf("t3_%0d", i), t3[i]);

    // Overlap mode, reconfigured from DONE
    do_cfg("t2_cfg", 8'b1011, 4'd4, 1'b1, 8'd0, mk(0, 0, 2, 0, 0, 0));
    do_start("t2_start", mk(0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 8; i++) apply_vec($sformatf("t2_%0d", i), t2[i]);

    // start ignored in IDLE; illegal lengths in IDLE
    do_start("idle_start", mk(0, 0, 2, 0, 1, 0));
    do_cfg("err_len0_idle", 8'h0B, 4'd0, 1'b0, 8'd0, mk(0, 0, 2, 0, 1, 1));
    apply("err_gap", mk(0, 0, 2, 0, 1, 0));
    do_cfg("err_len9_idle", 8'h0B, 4'd9, 1'b0, 8'd0, mk(0, 0, 2, 0, 1, 1));
    apply("err_gap2", mk(0, 0, 2, 0, 1, 0));

    // Gapped valid stream
    do_cfg("t4_cfg", 8'b1011, 4'd4, 1'b0, 8'd0, mk(0, 0, 2, 0, 0, 0));
    do_start("t4_start", mk(0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 8; i++) apply_vec($sformatf("t4_%0d", i), t4[i]);

    // Abort on the completing bit (continues the t4 run)
    for (int i = 0; i < 5; i++) apply_vec($sformatf("t5_%0d", i), t5[i]);

    // Asynchronous reset mid-run while match is high
    do_cfg("rst_cfg", 8'b1011, 4'd4, 1'b1, 8'd0, mk(0, 0, 1, 0, 0, 0));
    do_start("rst_start", mk(0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 4; i++) apply_vec($sformatf("rst_bit%0d", i), t2[i]);
    reset_n = 1'b0;
    #1;
    sb.push_back(mk(0, 0, 0, 0, 1, 0));
    check_pop("rst_async");
    tick();
    reset_n = 1'b1;
    apply("rst_after", mk(0, 0, 0, 0, 1, 0));

    // Saturation of the narrow counter
    do_cfg("sat_cfg", 8'b1, 4'd1, 1'b1, 8'd0, mk(0, 0, 0, 0, 0, 0));
    do_start("sat_start", mk(0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 6; i++) apply_vec($sformatf("sat_%0d", i), t6[i]);
    abort = 1'b1;
    apply("sat_abort", mk(0, 0, 5, 0, 1, 0));
    abort = 1'b0;

    // Maximum legal length
    do_cfg("full_cfg", 8'hA5, 4'd8, 1'b0, 8'd1, mk(0, 0, 5, 0, 0, 0));
    do_start("full_start", mk(0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 8; i++) apply_vec($sformatf("full_%0d", i), t7[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Run-time programmable serial pattern-detect controller for the sequence-detector datapath. It accepts a pattern configuration (bits, length, overlap mode, match target) through a valid/ready handshake and arms on a start strobe. While running it samples a qualified serial bit stream, pulses on every match, and counts matches. It reports completion when the target count is reached, so one block replaces per-pattern hard-coded detectors such as the fixed 1011 FSM.

## Interface
- PAT_W, 8: maximum pattern length in bits (≥2).
- CNT_W, 8: match counter / target width.
- LEN_W, $clog2(PAT_W)+1: width of cfg_len.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration can be accepted (IDLE or DONE).
- cfg_pattern  in  PAT_W  pattern; bit cfg_len-1 is received first, bit 0 last.
- cfg_len  in  LEN_W  pattern length, legal 1..PAT_W.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- cfg_target  in  CNT_W  match count that ends the run; 0 = run until abort.
- cfg_err  out  1  one-cycle pulse: illegal cfg_len rejected.
- start  in  1  begin run (ARMED or DONE).
- abort  in  1  stop run, return to IDLE.
- din_valid  in  1  din is valid this cycle.
- din  in  1  serial data bit.
- busy  out  1  high in RUN.
- match  out  1  one-cycle pulse per detected pattern.
- match_count  out  CNT_W  matches this run, saturating at 2^CNT_W-1.
- done  out  1  one-cycle pulse when match_count reaches cfg_target.

## Operation
- States: IDLE, ARMED, RUN, DONE. Reset → IDLE. All registers and outputs are 0 at reset.
- IDLE/DONE:
  - cfg_valid accepted when cfg_ready=1.
  - Legal cfg_len: latch all cfg fields and go to ARMED.
  - cfg_len=0 or >PAT_W: nothing latched, cfg_err pulses, state unchanged.
- ARMED:
  - start → RUN. Clear the shift register, bits_seen, and match_count.
  - cfg_ready=0 in ARMED; reconfiguration requires abort.
- DONE: start → RUN with the retained config, with the same clears as ARMED→RUN.
- RUN, on each din_valid cycle:
  - sh ← {sh[PAT_W-2:0], din}.
  - bits_seen ← min(bits_seen+1, PAT_W).
  - A hit occurs when bits_seen+1 ≥ len and the new sh[len-1:0] == pattern[len-1:0].
- On a hit:
  - match pulses.
  - match_count increments (saturating).
  - If cfg_overlap=0, bits_seen clears to 0 and the matched bits cannot be reused. If cfg_overlap=1, bits_seen is unchanged.
- If cfg_target≠0 and the incremented count == cfg_target: done pulses with match, and the next state is DONE. din is ignored in DONE.
- din_valid=0 in RUN: no state change; gaps are transparent.
- din/din_valid are ignored outside RUN. start is ignored in IDLE and RUN.
- abort in ARMED, RUN, or DONE → IDLE.
  - match_count holds its value until the next start.
  - No match or done pulse is issued for that cycle.
- Simultaneous events:
  - abort beats start, a hit, and cfg.
  - A hit and saturation in the same cycle still pulses match; the count stays at max.

## Timing
- match, done, match_count, and busy are registered.
- If the completing bit is sampled at edge k, match/done are high from edge k to edge k+1, and match_count shows the new value after edge k.
- Latency from the last pattern bit to match is 1 clock, the same as the existing registered-output detectors.
- busy rises the cycle after start is sampled and falls the cycle after done or abort.
- cfg_ready is combinational from state. A handshake completes on an edge where cfg_valid && cfg_ready.
- Asserting reset_n low mid-run clears everything immediately, with no pulse on match or done.

## Test plan
- Config 1011, len 4, overlap 0, target 2, start; stream 1,0,1,1,0,1,1 → match after the 4th bit only.
  - The 7th bit completes 1011 using the reused bits 1,0,1,1, which are consumed in non-overlap mode, so there is no second match.
  - Then stream 1,0,1,1 → match plus done, match_count=2, state DONE, busy=0.
- Same config with overlap 1, target 0; stream 1,0,1,1,0,1,1 → match after bits 4 and 7, match_count=2, no done.
- cfg_len=0 and cfg_len=PAT_W+1 → cfg_err pulse each, state IDLE, previous config retained.
- RUN with din_valid toggling 1/0 every cycle on 1,0,1,1 → exactly one match, 1 clock after the 4th valid bit.
- abort in the same cycle as a completing bit → no match pulse, IDLE next cycle, match_count unchanged. Reset_n pulsed low mid-run → all outputs 0 asynchronously.
- CNT_W=2, target 0, 5 matches → match_count saturates at 3, and match still pulses 5 times.
